output_collector: RTL and testbench
===================================

OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 16, meaning the width of one output sample.
REQ-002 SHALL have parameter EXT_MEM_WIDTH, default 32 (2*IO_DATA_WIDTH), meaning the width of the packed memory word.
REQ-003 SHALL have parameter EXT_MEM_HEIGHT, default 256, meaning the number of memory words; the address wraps modulo this value.
REQ-004 SHALL have parameters FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT and OUTPUT_NB_CHANNELS, defaults 1024, 1024 and 64, meaning the output tensor geometry.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (power of two), meaning the depth of the packed-word queue.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_in  input  1  synchronous, active-high reset.
REQ-008 in_data  input  IO_DATA_WIDTH  signed output sample from the convolution chip.
REQ-009 in_valid  input  1  sample qualifier; the producer has no ready, so every valid sample must be taken or counted as dropped.
REQ-010 in_x, in_y, in_ch  input  $clog2 of the matching geometry parameter  coordinates of the sample.
REQ-011 flush  input  1  end of frame; forces any held half-word out.
REQ-012 mem_grant  input  1  memory accepts a write in the current cycle.
REQ-013 mem_write_en, mem_write_addr, mem_din  output  1, $clog2(EXT_MEM_HEIGHT), EXT_MEM_WIDTH  memory write port.
REQ-014 overflow, pair_error  output  1 each  sticky error flags.
REQ-015 words_written  output  16  count of completed memory writes, saturating at 0xFFFF.
REQ-016 idle  output  1  high when the FIFO is empty and no half-word is held.

Function
REQ-017 SHALL pack each even channel c and channel c+1 at the same (x,y) into one word: even channel in the low half, odd channel in the high half.
REQ-018 SHALL compute the word address as (((y*FEATURE_MAP_WIDTH + x)*OUTPUT_NB_CHANNELS + c) >> 1) mod EXT_MEM_HEIGHT, where c is the even channel, with a 32-bit intermediate and truncation.
REQ-019 SHALL implement the pairing FSM with two states:
- EMPTY: a valid even-channel sample stores the low half and moves to HALF.
- EMPTY: a valid odd-channel sample pushes word {sample, 0} with its own address, sets pair_error, and stays in EMPTY.
- HALF: a valid partner (c+1, same x and y) pushes the full word and moves to EMPTY.
- HALF: any other valid sample pushes the held word {0, low} and sets pair_error, then processes the new sample as if in EMPTY.
REQ-020 When the FSM is in HALF, a flush without a valid sample SHALL push the held word {0, low} and move to EMPTY without setting pair_error.
REQ-021 When flush and in_valid occur in the same cycle, SHALL process the sample first; if the result leaves a half-word held, that half-word is flushed in the next cycle.
REQ-022 SHALL push at most one word per cycle; where REQ-019 requires two pushes in one cycle, the second (the odd-channel word) is deferred one cycle through a single-entry skid register.
REQ-023 Output timing: the packed-word queue SHALL be a FIFO, drained as follows.
- mem_write_en = FIFO not empty AND mem_grant.
- mem_din and mem_write_addr present the FIFO head combinationally.
- A pop occurs in each cycle that mem_write_en is high.
REQ-024 Latency: a pair completed by the sample in cycle N SHALL appear on mem_write_en in cycle N+1, provided the FIFO was empty and mem_grant is high.
REQ-025 FIFO full: a push with a simultaneous pop SHALL succeed; a push without a pop SHALL drop the word and set overflow.
REQ-026 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to distinguish full from empty.
REQ-027 words_written SHALL increment on each mem_write_en.

Reset
REQ-028 rst_in SHALL, in the same cycle:
- set the FSM to EMPTY and clear the skid register;
- clear the FIFO, overflow, pair_error and words_written;
- drive mem_write_en to 0 and mem_din and mem_write_addr to 0;
- drive idle to 1.
REQ-029 Reset asserted mid-operation SHALL discard held and queued data with no partial write, and in_valid SHALL be ignored during the reset cycle.

Structure
REQ-030 The geometry parameter defaults, the packed-word typedef {hi, lo} and the FSM state enum SHALL live in a shared package, collector_pkg.
REQ-031 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth.

Verification
REQ-032 Pair path: ch0=0x1111 then ch1=0x2222 at x=1, y=0, with mem_grant=1 -> one write of 0x22221111 at address 32, one cycle after the ch1 sample.
REQ-033 Broken pair: ch2=0x0005 then ch4=0x0007 -> word 0x00000005 is written and pair_error=1; ch4 is held, and a following flush writes 0x00000007.
REQ-034 Overflow: mem_grant=0 with 5 full pairs pushed -> 4 words queued and overflow=1; setting mem_grant=1 then produces exactly 4 writes and words_written=4.
REQ-035 Full with simultaneous push and pop: 4 words queued, mem_grant=1 and a new pair completing in the same cycle -> no overflow, and the FIFO stays at 4 entries.
REQ-036 Address wrap: y=0, x=8, ch=0 -> address 0 ((8*64)>>1 = 256 mod 256).
REQ-037 Reset while the FSM is in HALF with 2 words queued -> the next cycle shows idle=1 and words_written=0, and no write follows.

Source files
------------

// File: rtl/collector_pkg.sv
// Shared geometry defaults, packed memory word and pairing FSM states
// for the convolution output collector.
package collector_pkg;

  localparam int IO_W = 16;
  localparam int MEM_W = 2 * IO_W;
  localparam int MEM_H = 256;
  localparam int FM_W = 1024;
  localparam int FM_H = 1024;
  localparam int NB_CH = 64;
  localparam int FIFO_D = 4;

  typedef struct packed {
    logic [IO_W-1:0] hi;
    logic [IO_W-1:0] lo;
  } word_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; push while full only
// succeeds when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[PW] != rd_ptr[PW]) &&
                (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/output_collector.sv
// Pairs even/odd channel samples into packed memory words and drains
// them through a FIFO to a granted external memory write port.
module output_collector
  import collector_pkg::*;
#(
  parameter int IO_DATA_WIDTH = IO_W,
  parameter int EXT_MEM_WIDTH = MEM_W,
  parameter int EXT_MEM_HEIGHT = MEM_H,
  parameter int FEATURE_MAP_WIDTH = FM_W,
  parameter int FEATURE_MAP_HEIGHT = FM_H,
  parameter int OUTPUT_NB_CHANNELS = NB_CH,
  parameter int FIFO_DEPTH = FIFO_D,
  localparam int XW = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CW = $clog2(OUTPUT_NB_CHANNELS),
  localparam int AW = $clog2(EXT_MEM_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic [IO_DATA_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  input  logic [XW-1:0]            in_x,
  input  logic [YW-1:0]            in_y,
  input  logic [CW-1:0]            in_ch,
  input  logic                     flush,
  input  logic                     mem_grant,
  output logic                     mem_write_en,
  output logic [AW-1:0]            mem_write_addr,
  output logic [EXT_MEM_WIDTH-1:0] mem_din,
  output logic                     overflow,
  output logic                     pair_error,
  output logic [15:0]              words_written,
  output logic                     idle
);

  typedef struct packed {
    logic [AW-1:0] addr;
    word_t         w;
  } entry_t;

  function automatic logic [AW-1:0] addr_of(
    input logic [YW-1:0] y,
    input logic [XW-1:0] x,
    input logic [CW-1:0] c
  );
    logic [31:0] lin;
    lin = (32'(y) * 32'(FEATURE_MAP_WIDTH) + 32'(x))
          * 32'(OUTPUT_NB_CHANNELS) + 32'(c);
    return AW'((lin >> 1) % 32'(EXT_MEM_HEIGHT));
  endfunction

  state_t          state, state_n;
  logic [IO_W-1:0] low, low_n;
  logic [XW-1:0]   hold_x, hold_x_n;
  logic [YW-1:0]   hold_y, hold_y_n;
  logic [CW-1:0]   hold_ch, hold_ch_n;
  logic [AW-1:0]   hold_addr, hold_addr_n;
  logic            flush_pend, flush_pend_n;
  logic            skid_v, skid_v_n;
  entry_t          skid, skid_n;
  logic            a_v, b_v;
  entry_t          a_e, b_e;
  logic            perr_set;
  logic            push;
  entry_t          push_e;
  entry_t          head;
  logic            fifo_full, fifo_empty;
  logic            pop;
  logic [IO_W-1:0] sample;
  logic [AW-1:0]   in_addr;
  logic            eff_flush;
  logic            partner;

  assign sample = IO_W'(in_data);
  assign in_addr = addr_of(in_y, in_x, in_ch);
  assign eff_flush = flush || flush_pend;
  assign partner = in_ch[0] && (in_x == hold_x) &&
                   (in_y == hold_y) &&
                   (in_ch == (hold_ch | CW'(1)));

  always_comb begin
    state_n = state;
    low_n = low;
    hold_x_n = hold_x;
    hold_y_n = hold_y;
    hold_ch_n = hold_ch;
    hold_addr_n = hold_addr;
    flush_pend_n = 1'b0;
    a_v = 1'b0;
    a_e = '0;
    b_v = 1'b0;
    b_e = '0;
    perr_set = 1'b0;
    if (in_valid) begin
      unique case (state)
        EMPTY: begin
          if (!in_ch[0]) begin
            state_n = HALF;
          end else begin
            a_v = 1'b1;
            a_e = '{addr: in_addr, w: '{hi: sample, lo: '0}};
            perr_set = 1'b1;
          end
        end
        HALF: begin
          a_v = 1'b1;
          if (partner) begin
            a_e = '{addr: hold_addr, w: '{hi: sample, lo: low}};
            state_n = EMPTY;
          end else begin
            a_e = '{addr: hold_addr, w: '{hi: '0, lo: low}};
            perr_set = 1'b1;
            if (in_ch[0]) begin
              b_v = 1'b1;
              b_e = '{addr: in_addr, w: '{hi: sample, lo: '0}};
              state_n = EMPTY;
            end
          end
        end
        default: state_n = EMPTY;
      endcase
      if (!in_ch[0] && !(state == HALF && partner)) begin
        low_n = sample;
        hold_x_n = in_x;
        hold_y_n = in_y;
        hold_ch_n = in_ch;
        hold_addr_n = in_addr;
      end
      flush_pend_n = eff_flush && (state_n == HALF);
    end else if (eff_flush && state == HALF) begin
      a_v = 1'b1;
      a_e = '{addr: hold_addr, w: '{hi: '0, lo: low}};
      state_n = EMPTY;
    end
  end

  // Skid entry always goes first; the FSM never yields two words
  // while the skid is occupied, so nothing is lost here.
  always_comb begin
    push = 1'b0;
    push_e = '0;
    skid_v_n = 1'b0;
    skid_n = '0;
    if (skid_v) begin
      push = 1'b1;
      push_e = skid;
      skid_v_n = a_v;
      skid_n = a_e;
    end else if (a_v) begin
      push = 1'b1;
      push_e = a_e;
      skid_v_n = b_v;
      skid_n = b_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= EMPTY;
      low <= '0;
      hold_x <= '0;
      hold_y <= '0;
      hold_ch <= '0;
      hold_addr <= '0;
      flush_pend <= 1'b0;
      skid_v <= 1'b0;
      skid <= '0;
      overflow <= 1'b0;
      pair_error <= 1'b0;
      words_written <= '0;
    end else begin
      state <= state_n;
      low <= low_n;
      hold_x <= hold_x_n;
      hold_y <= hold_y_n;
      hold_ch <= hold_ch_n;
      hold_addr <= hold_addr_n;
      flush_pend <= flush_pend_n;
      skid_v <= skid_v_n;
      skid <= skid_n;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (perr_set) pair_error <= 1'b1;
      if (pop && words_written != 16'hFFFF)
        words_written <= words_written + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst_in(rst_in),
    .push(push),
    .din(push_e),
    .pop(pop),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );

  assign pop = !fifo_empty && mem_grant && !rst_in;
  assign mem_write_en = pop;
  assign mem_write_addr = rst_in ? '0 : head.addr;
  assign mem_din = rst_in ? '0 : EXT_MEM_WIDTH'(head.w);
  assign idle = rst_in ||
                (fifo_empty && state == EMPTY && !skid_v);

endmodule

// File: tb/tb_output_collector.sv
// Directed self-checking bench for output_collector.
// Writes are logged on the falling edge; each task checks its own scenario.
module tb_output_collector;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [15:0] in_data;
  logic        in_valid;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic [5:0]  in_ch;
  logic        flush;
  logic        mem_grant;
  logic        mem_write_en;
  logic [7:0]  mem_write_addr;
  logic [31:0] mem_din;
  logic        overflow;
  logic        pair_error;
  logic [15:0] words_written;
  logic        idle;

  int tests = 0;
  int fails = 0;
  logic [7:0]  log_addr[$];
  logic [31:0] log_din[$];

  always #5 clk = ~clk;

  output_collector dut (
    .clk(clk),
    .rst_in(rst_in),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_x(in_x),
    .in_y(in_y),
    .in_ch(in_ch),
    .flush(flush),
    .mem_grant(mem_grant),
    .mem_write_en(mem_write_en),
    .mem_write_addr(mem_write_addr),
    .mem_din(mem_din),
    .overflow(overflow),
    .pair_error(pair_error),
    .words_written(words_written),
    .idle(idle)
  );

  always @(negedge clk) begin
    if (mem_write_en) begin
      log_addr.push_back(mem_write_addr);
      log_din.push_back(mem_din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input int x, input int y,
                      input int c, input logic f);
    in_valid = 1'b1;
    in_data = d;
    in_x = 10'(x);
    in_y = 10'(y);
    in_ch = 6'(c);
    flush = f;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send_pair(input int k);
    send(16'h0100 + 16'(k), k, 0, 0, 1'b0);
    send(16'h0200 + 16'(k), k, 0, 1, 1'b0);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b0) begin fails++;
      $display("FAIL rst_en got %b want 0", mem_write_en); end
    tests++; if (idle !== 1'b1) begin fails++;
      $display("FAIL rst_idle got %b want 1", idle); end
    tests++; if (mem_din !== 32'h0) begin fails++;
      $display("FAIL rst_din got %h want 0", mem_din); end
    tests++; if (mem_write_addr !== 8'h0) begin fails++;
      $display("FAIL rst_addr got %h want 0", mem_write_addr); end
    tick();
    rst_in = 1'b0;
    @(negedge clk);
    tests++; if (words_written !== 16'h0) begin fails++;
      $display("FAIL rst_ww got %0d want 0", words_written); end
    tests++; if ({overflow, pair_error} !== 2'b00) begin fails++;
      $display("FAIL rst_flags got %b want 00", {overflow, pair_error}); end
    tick();
  endtask

  task automatic test_pair();
    do_reset();
    mem_grant = 1'b1;
    send(16'h1111, 1, 0, 0, 1'b0);
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b0) begin fails++;
      $display("FAIL pair_half_en got %b want 0", mem_write_en); end
    send(16'h2222, 1, 0, 1, 1'b0);
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b1) begin fails++;
      $display("FAIL pair_en got %b want 1", mem_write_en); end
    tests++; if (mem_din !== 32'h22221111) begin fails++;
      $display("FAIL pair_din got %h want 22221111", mem_din); end
    tests++; if (mem_write_addr !== 8'd32) begin fails++;
      $display("FAIL pair_addr got %0d want 32", mem_write_addr); end
    tick();
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b0) begin fails++;
      $display("FAIL pair_after_en got %b want 0", mem_write_en); end
    tests++; if (words_written !== 16'd1) begin fails++;
      $display("FAIL pair_ww got %0d want 1", words_written); end
    tests++; if (pair_error !== 1'b0) begin fails++;
      $display("FAIL pair_perr got %b want 0", pair_error); end
  endtask

  task automatic test_broken_pair();
    do_reset();
    mem_grant = 1'b1;
    send(16'h0005, 0, 0, 2, 1'b0);
    send(16'h0007, 0, 0, 4, 1'b0);
    @(negedge clk);
    tests++; if (mem_din !== 32'h00000005 || mem_write_en !== 1'b1)
      begin fails++;
      $display("FAIL broken_din got %h en %b want 00000005 en 1",
               mem_din, mem_write_en); end
    tests++; if (mem_write_addr !== 8'd1) begin fails++;
      $display("FAIL broken_addr got %0d want 1", mem_write_addr); end
    tests++; if (pair_error !== 1'b1) begin fails++;
      $display("FAIL broken_perr got %b want 1", pair_error); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    tests++; if (mem_din !== 32'h00000007 || mem_write_en !== 1'b1)
      begin fails++;
      $display("FAIL broken_flush got %h en %b want 00000007 en 1",
               mem_din, mem_write_en); end
    tests++; if (mem_write_addr !== 8'd2) begin fails++;
      $display("FAIL broken_flush_addr got %0d want 2", mem_write_addr); end
    tick();
    @(negedge clk);
    tests++; if (idle !== 1'b1) begin fails++;
      $display("FAIL broken_idle got %b want 1", idle); end
  endtask

  task automatic test_odd_first();
    do_reset();
    mem_grant = 1'b1;
    send(16'h0033, 0, 0, 3, 1'b0);
    @(negedge clk);
    tests++; if (mem_din !== 32'h00330000 || mem_write_en !== 1'b1)
      begin fails++;
      $display("FAIL odd_din got %h en %b want 00330000 en 1",
               mem_din, mem_write_en); end
    tests++; if (mem_write_addr !== 8'd1) begin fails++;
      $display("FAIL odd_addr got %0d want 1", mem_write_addr); end
    tests++; if (pair_error !== 1'b1) begin fails++;
      $display("FAIL odd_perr got %b want 1", pair_error); end
  endtask

  task automatic test_skid();
    do_reset();
    mem_grant = 1'b1;
    log_addr.delete();
    log_din.delete();
    send(16'h00AA, 0, 0, 0, 1'b0);
    send(16'h00BB, 0, 0, 3, 1'b0);
    repeat (3) tick();
    tests++; if (log_din.size() !== 2) begin fails++;
      $display("FAIL skid_count got %0d want 2", log_din.size()); end
    else begin
      tests++; if (log_din[0] !== 32'h000000AA || log_addr[0] !== 8'd0)
        begin fails++;
        $display("FAIL skid_w0 got %h@%0d want 000000aa@0",
                 log_din[0], log_addr[0]); end
      tests++; if (log_din[1] !== 32'h00BB0000 || log_addr[1] !== 8'd1)
        begin fails++;
        $display("FAIL skid_w1 got %h@%0d want 00bb0000@1",
                 log_din[1], log_addr[1]); end
    end
  endtask

  task automatic test_wrap_flush();
    do_reset();
    mem_grant = 1'b1;
    send(16'hABCD, 8, 0, 0, 1'b1);
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b0) begin fails++;
      $display("FAIL wrap_early_en got %b want 0", mem_write_en); end
    tick();
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b1 || mem_din !== 32'h0000ABCD)
      begin fails++;
      $display("FAIL wrap_din got %h en %b want 0000abcd en 1",
               mem_din, mem_write_en); end
    tests++; if (mem_write_addr !== 8'd0) begin fails++;
      $display("FAIL wrap_addr got %0d want 0", mem_write_addr); end
    tests++; if (pair_error !== 1'b0) begin fails++;
      $display("FAIL wrap_perr got %b want 0", pair_error); end
  endtask

  task automatic test_overflow();
    do_reset();
    mem_grant = 1'b0;
    for (int k = 0; k < 5; k++) send_pair(k);
    @(negedge clk);
    tests++; if (overflow !== 1'b1) begin fails++;
      $display("FAIL ovf_flag got %b want 1", overflow); end
    tests++; if (mem_write_en !== 1'b0) begin fails++;
      $display("FAIL ovf_en got %b want 0", mem_write_en); end
    tick();
    log_addr.delete();
    log_din.delete();
    mem_grant = 1'b1;
    repeat (6) tick();
    tests++; if (log_din.size() !== 4) begin fails++;
      $display("FAIL ovf_count got %0d want 4", log_din.size()); end
    else begin
      tests++; if (log_din[0] !== 32'h02000100 || log_addr[0] !== 8'd0)
        begin fails++;
        $display("FAIL ovf_w0 got %h@%0d want 02000100@0",
                 log_din[0], log_addr[0]); end
      tests++; if (log_din[3] !== 32'h02030103 || log_addr[3] !== 8'd96)
        begin fails++;
        $display("FAIL ovf_w3 got %h@%0d want 02030103@96",
                 log_din[3], log_addr[3]); end
    end
    tests++; if (words_written !== 16'd4) begin fails++;
      $display("FAIL ovf_ww got %0d want 4", words_written); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    mem_grant = 1'b0;
    for (int k = 0; k < 4; k++) send_pair(k);
    send(16'h0104, 4, 0, 0, 1'b0);
    log_addr.delete();
    log_din.delete();
    mem_grant = 1'b1;
    send(16'h0204, 4, 0, 1, 1'b0);
    repeat (6) tick();
    tests++; if (overflow !== 1'b0) begin fails++;
      $display("FAIL full_ovf got %b want 0", overflow); end
    tests++; if (log_din.size() !== 5) begin fails++;
      $display("FAIL full_count got %0d want 5", log_din.size()); end
    else begin
      tests++; if (log_din[4] !== 32'h02040104 || log_addr[4] !== 8'd128)
        begin fails++;
        $display("FAIL full_w4 got %h@%0d want 02040104@128",
                 log_din[4], log_addr[4]); end
    end
    tests++; if (words_written !== 16'd5) begin fails++;
      $display("FAIL full_ww got %0d want 5", words_written); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_grant = 1'b0;
    send_pair(0);
    send_pair(1);
    send(16'h0102, 2, 0, 0, 1'b0);
    @(negedge clk);
    tests++; if (idle !== 1'b0) begin fails++;
      $display("FAIL mid_busy got %b want 0", idle); end
    tick();
    log_addr.delete();
    log_din.delete();
    rst_in = 1'b1;
    mem_grant = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h0202;
    in_x = 10'd2;
    in_y = 10'd0;
    in_ch = 6'd1;
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b0 || idle !== 1'b1) begin fails++;
      $display("FAIL mid_rst_out got en %b idle %b want en 0 idle 1",
               mem_write_en, idle); end
    tick();
    rst_in = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (idle !== 1'b1) begin fails++;
      $display("FAIL mid_idle got %b want 1", idle); end
    tests++; if (words_written !== 16'd0) begin fails++;
      $display("FAIL mid_ww got %0d want 0", words_written); end
    repeat (4) tick();
    tests++; if (log_din.size() !== 0) begin fails++;
      $display("FAIL mid_writes got %0d want 0", log_din.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_x = '0;
    in_y = '0;
    in_ch = '0;
    flush = 1'b0;
    mem_grant = 1'b0;
    tick();
    test_reset();
    test_pair();
    test_broken_pair();
    test_odd_first();
    test_skid();
    test_wrap_flush();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
